// File: rtl/lm32_tlb_maint_ctrl_if.sv
// Command handshake and shared TLB write bus between the CSR decode logic
// and the TLB maintenance controller.
interface lm32_tlb_maint_ctrl_if #(
    parameter int unsigned sets      = 1024,
    parameter int unsigned page_size = 4096
);
    localparam int unsigned IW = $clog2(sets);
    localparam int unsigned PW = 32 - $clog2(page_size);
    localparam int unsigned TW = PW - IW;
    localparam int unsigned EW = PW + TW + 1;

    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [1:0]    cmd_target;
    logic [31:0]   cmd_vaddr;
    logic [31:0]   cmd_paddr;
    logic [IW-1:0] tlb_index;
    logic [EW-1:0] tlb_wdata;
    logic          itlb_we;
    logic          dtlb_we;
    logic          stall_request;
    logic          busy;
    logic          flush_done;

    modport master (
        output cmd_valid, cmd_op, cmd_target, cmd_vaddr, cmd_paddr,
        input  cmd_ready, tlb_index, tlb_wdata, itlb_we, dtlb_we,
               stall_request, busy, flush_done
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_target, cmd_vaddr, cmd_paddr,
        output cmd_ready, tlb_index, tlb_wdata, itlb_we, dtlb_we,
               stall_request, busy, flush_done
    );
endinterface

// File: rtl/lm32_tlb_maint_ctrl.sv
// Queues ITLB/DTLB maintenance commands and sequences the RAM writes:
// single-entry update/invalidate, full flush, and a flush of both TLBs out of reset.
module lm32_tlb_maint_ctrl #(
    parameter int unsigned sets       = 1024,
    parameter int unsigned page_size  = 4096,
    parameter int unsigned fifo_depth = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    lm32_tlb_maint_ctrl_if.slave  bus
);
    localparam int unsigned OFF = $clog2(page_size);
    localparam int unsigned IW  = $clog2(sets);
    localparam int unsigned PW  = 32 - OFF;
    localparam int unsigned TW  = PW - IW;
    localparam int unsigned EW  = PW + TW + 1;
    localparam int unsigned AW  = $clog2(fifo_depth);
    localparam int unsigned CW  = AW + 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(sets - 1);

    typedef enum logic [1:0] {IDLE, EXEC, FLUSH, DONE} state_e;
    typedef enum logic [1:0] {OP_NOP, OP_UPDATE, OP_INVAL, OP_FLUSH} op_e;

    // Only the page-number bits of each address are ever used, so only those are queued.
    typedef struct packed {
        op_e           op;
        logic [1:0]    tgt;
        logic [PW-1:0] vpn;
        logic [PW-1:0] ppn;
    } cmd_t;

    cmd_t          fifo_mem_q [fifo_depth];
    cmd_t          head;
    cmd_t          push_cmd;
    logic          push;
    logic          pop;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    state_e        state_q, state_d;
    cmd_t          cur_q, cur_d;
    logic [IW-1:0] flush_idx_q, flush_idx_d;
    logic          rflush_q, rflush_d;

    logic [IW-1:0] tlb_index_q, tlb_index_d;
    logic [EW-1:0] tlb_wdata_q, tlb_wdata_d;
    logic          itlb_we_q, itlb_we_d;
    logic          dtlb_we_q, dtlb_we_d;
    logic          stall_q, stall_d;
    logic          busy_q, busy_d;
    logic          flush_done_q, flush_done_d;
    logic          cmd_ready_q, cmd_ready_d;
    logic          unused_addr_bits;

    assign unused_addr_bits = ^{bus.cmd_vaddr[OFF-1:0], bus.cmd_paddr[OFF-1:0]};

    always_comb begin
        head     = fifo_mem_q[rd_ptr_q];
        push_cmd = '{op: op_e'(bus.cmd_op), tgt: bus.cmd_target,
                     vpn: bus.cmd_vaddr[31:OFF], ppn: bus.cmd_paddr[31:OFF]};
        push     = bus.cmd_valid && cmd_ready_q;
        pop      = (state_q == IDLE) && (count_q != '0);
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);

        state_d      = state_q;
        cur_d        = cur_q;
        flush_idx_d  = flush_idx_q;
        rflush_d     = rflush_q;
        tlb_index_d  = tlb_index_q;
        tlb_wdata_d  = '0;
        itlb_we_d    = 1'b0;
        dtlb_we_d    = 1'b0;
        stall_d      = 1'b0;
        flush_done_d = 1'b0;

        // Outputs are loaded with the action of the current state, so they trail it by one cycle.
        unique case (state_q)
            IDLE: begin
                if (pop) begin
                    cur_d = head;
                    if (head.tgt != 2'b00) begin
                        case (head.op)
                            OP_UPDATE, OP_INVAL: state_d = EXEC;
                            OP_FLUSH: begin
                                state_d     = FLUSH;
                                flush_idx_d = LAST_IDX;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            EXEC: begin
                tlb_index_d = cur_q.vpn[IW-1:0];
                tlb_wdata_d = (cur_q.op == OP_UPDATE) ? {1'b1, cur_q.vpn[PW-1:IW], cur_q.ppn} : '0;
                itlb_we_d   = cur_q.tgt[0];
                dtlb_we_d   = cur_q.tgt[1];
                state_d     = IDLE;
            end
            FLUSH: begin
                tlb_index_d = flush_idx_q;
                itlb_we_d   = cur_q.tgt[0];
                dtlb_we_d   = cur_q.tgt[1];
                stall_d     = 1'b1;
                if (flush_idx_q == '0) begin
                    state_d = DONE;
                end else begin
                    flush_idx_d = flush_idx_q - IW'(1);
                end
            end
            DONE: begin
                flush_done_d = 1'b1;
                rflush_d     = 1'b0;
                state_d      = IDLE;
            end
        endcase

        busy_d      = (state_q != IDLE) || (state_d != IDLE) || (count_d != '0);
        cmd_ready_d = (count_d != CW'(fifo_depth)) && !rflush_d;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q      <= FLUSH;
            cur_q        <= '{op: OP_FLUSH, tgt: 2'b11, vpn: '0, ppn: '0};
            flush_idx_q  <= LAST_IDX;
            rflush_q     <= 1'b1;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            tlb_index_q  <= '0;
            tlb_wdata_q  <= '0;
            itlb_we_q    <= 1'b0;
            dtlb_we_q    <= 1'b0;
            stall_q      <= 1'b0;
            busy_q       <= 1'b0;
            flush_done_q <= 1'b0;
            cmd_ready_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_q        <= cur_d;
            flush_idx_q  <= flush_idx_d;
            rflush_q     <= rflush_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            tlb_index_q  <= tlb_index_d;
            tlb_wdata_q  <= tlb_wdata_d;
            itlb_we_q    <= itlb_we_d;
            dtlb_we_q    <= dtlb_we_d;
            stall_q      <= stall_d;
            busy_q       <= busy_d;
            flush_done_q <= flush_done_d;
            cmd_ready_q  <= cmd_ready_d;
            if (push) begin
                fifo_mem_q[wr_ptr_q] <= push_cmd;
            end
        end
    end

    assign bus.cmd_ready     = cmd_ready_q;
    assign bus.tlb_index     = tlb_index_q;
    assign bus.tlb_wdata     = tlb_wdata_q;
    assign bus.itlb_we       = itlb_we_q;
    assign bus.dtlb_we       = dtlb_we_q;
    assign bus.stall_request = stall_q;
    assign bus.busy          = busy_q;
    assign bus.flush_done    = flush_done_q;
endmodule

// File: tb/tb_lm32_tlb_maint_ctrl.sv
// Bench for lm32_tlb_maint_ctrl: a queue of expected RAM writes and flush-done
// events is filled at command acceptance and drained by an output monitor.
module tb_lm32_tlb_maint_ctrl;
    localparam int unsigned SETS  = 1024;
    localparam int unsigned PAGE  = 4096;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned IW    = $clog2(SETS);
    localparam int unsigned PW    = 32 - $clog2(PAGE);
    localparam int unsigned EW    = PW + (PW - IW) + 1;

    typedef struct {
        bit            done;
        bit            flush;
        logic [IW-1:0] idx;
        logic [EW-1:0] data;
        logic [1:0]    we;
    } exp_t;

    logic clk = 1'b0;
    logic rst_i = 1'b0;
    bit   mon_en = 1'b0;
    int unsigned n_checks = 0;
    int unsigned n_fail = 0;
    exp_t exp_q[$];

    lm32_tlb_maint_ctrl_if #(.sets(SETS), .page_size(PAGE)) bus ();

    lm32_tlb_maint_ctrl #(.sets(SETS), .page_size(PAGE), .fifo_depth(DEPTH)) dut (
        .clk_i (clk),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_flush(input logic [1:0] tgt);
        exp_t e;
        for (int i = int'(SETS) - 1; i >= 0; i--) begin
            e = '{done: 1'b0, flush: 1'b1, idx: IW'(i), data: '0, we: tgt};
            exp_q.push_back(e);
        end
        e = '{done: 1'b1, flush: 1'b0, idx: '0, data: '0, we: 2'b00};
        exp_q.push_back(e);
    endtask

    // Reference: entry index = page number mod sets, tag = page number / sets.
    task automatic model_accept(input logic [1:0] op, input logic [1:0] tgt,
                                input logic [31:0] va, input logic [31:0] pa);
        exp_t e;
        longint unsigned vpage, ppage, word;
        if (op == 2'd0 || tgt == 2'b00) return;
        if (op == 2'd3) begin
            push_flush(tgt);
            return;
        end
        vpage = longint'(va) / PAGE;
        ppage = longint'(pa) / PAGE;
        word  = (longint'(1) << (EW - 1)) + (vpage / SETS) * (longint'(1) << PW) + ppage;
        e = '{done: 1'b0, flush: 1'b0, idx: IW'(vpage % SETS),
              data: (op == 2'd1) ? EW'(word) : '0, we: tgt};
        exp_q.push_back(e);
    endtask

    // Entered at a negedge; returns at a negedge.
    task automatic send(input logic [1:0] op, input logic [1:0] tgt, input logic [31:0] va,
                        input logic [31:0] pa, input int unsigned tries, output bit ok);
        bit rdy;
        ok = 1'b0;
        bus.cmd_valid  = 1'b1;
        bus.cmd_op     = op;
        bus.cmd_target = tgt;
        bus.cmd_vaddr  = va;
        bus.cmd_paddr  = pa;
        for (int unsigned i = 0; i < tries && !ok; i++) begin
            rdy = bus.cmd_ready;
            @(posedge clk);
            if (rdy) begin
                ok = 1'b1;
                model_accept(op, tgt, va, pa);
            end
            @(negedge clk);
        end
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int unsigned budget);
        bit reached = 1'b0;
        for (int unsigned i = 0; i < budget && !reached; i++) begin
            @(posedge clk); #1;
            if (!bus.busy && exp_q.size() == 0) reached = 1'b1;
        end
        check(name, 64'(reached), 64'd1);
        @(negedge clk);
    endtask

    task automatic do_reset(input int unsigned hold);
        int unsigned stall_cnt = 0, done_cnt = 0, ready_in_flush = 0;
        @(negedge clk);
        mon_en = 1'b0;
        rst_i = 1'b0;
        bus.cmd_valid = 1'b0;
        repeat (hold) @(negedge clk);
        check("rst_itlb_we", 64'(bus.itlb_we), 64'd0);
        check("rst_dtlb_we", 64'(bus.dtlb_we), 64'd0);
        check("rst_wdata", 64'(bus.tlb_wdata), 64'd0);
        check("rst_flush_done", 64'(bus.flush_done), 64'd0);
        check("rst_cmd_ready", 64'(bus.cmd_ready), 64'd0);
        exp_q.delete();
        push_flush(2'b11);
        rst_i = 1'b1;
        mon_en = 1'b1;
        for (int unsigned i = 0; i < 1100; i++) begin
            @(posedge clk); #1;
            if (i == 0) begin
                check("rflush_first_stall", 64'(bus.stall_request), 64'd1);
                check("rflush_first_busy", 64'(bus.busy), 64'd1);
            end
            if (bus.stall_request) stall_cnt++;
            if (bus.flush_done) done_cnt++;
            if (bus.stall_request && bus.cmd_ready) ready_in_flush++;
        end
        check("rflush_stall_cycles", 64'(stall_cnt), 64'd1024);
        check("rflush_done_pulses", 64'(done_cnt), 64'd1);
        check("rflush_ready_low", 64'(ready_in_flush), 64'd0);
        check("rflush_busy_after", 64'(bus.busy), 64'd0);
        check("rflush_ready_after", 64'(bus.cmd_ready), 64'd1);
        @(negedge clk);
    endtask

    always begin : monitor
        exp_t e;
        @(posedge clk); #1;
        if (mon_en) begin
            if (bus.itlb_we || bus.dtlb_we) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: got index 0x%0h data 0x%0h we %b%b, expected none",
                             bus.tlb_index, bus.tlb_wdata, bus.dtlb_we, bus.itlb_we);
                end else begin
                    e = exp_q.pop_front();
                    check("write_kind", 64'(e.done), 64'd0);
                    check("write_index", 64'(bus.tlb_index), 64'(e.idx));
                    check("write_data", 64'(bus.tlb_wdata), 64'(e.data));
                    check("write_strobes", 64'({bus.dtlb_we, bus.itlb_we}), 64'(e.we));
                    check("write_stall", 64'(bus.stall_request), 64'(e.flush));
                end
            end else if (bus.flush_done) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_flush_done: got 1, expected 0");
                end else begin
                    e = exp_q.pop_front();
                    check("flush_done_order", 64'(e.done), 64'd1);
                end
            end else begin
                check("stall_when_idle", 64'(bus.stall_request), 64'd0);
            end
        end
    end

    initial begin : watchdog
        #900000;
        n_fail++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : stimulus
        bit ok;
        int unsigned lat, nacc, nfound, nstrobe, flushes;
        int unsigned cyc;
        int unsigned t[4];
        bit seen_done;
        logic [1:0] op, tgt;

        bus.cmd_valid  = 1'b0;
        bus.cmd_op     = '0;
        bus.cmd_target = '0;
        bus.cmd_vaddr  = '0;
        bus.cmd_paddr  = '0;

        do_reset(3);

        // UPDATE to DTLB with fixed values and latency.
        send(2'd1, 2'b10, 32'h1234_5000, 32'hABCD_E000, 4, ok);
        check("upd_accept", 64'(ok), 64'd1);
        lat = 0;
        for (int unsigned i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            lat++;
            if (bus.itlb_we || bus.dtlb_we) break;
        end
        check("upd_latency", 64'(lat), 64'd2);
        check("upd_index", 64'(bus.tlb_index), 64'h345);
        check("upd_wdata", 64'(bus.tlb_wdata), 64'({1'b1, 10'h048, 20'hABCDE}));
        check("upd_itlb_we", 64'(bus.itlb_we), 64'd0);
        @(negedge clk);
        wait_idle("upd_idle", 20);

        // INVALIDATE both: exactly one strobe cycle.
        send(2'd2, 2'b11, 32'h0000_7000, 32'h0, 4, ok);
        check("inv_accept", 64'(ok), 64'd1);
        nstrobe = 0;
        for (int unsigned i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (bus.itlb_we && bus.dtlb_we) begin
                nstrobe++;
                check("inv_index", 64'(bus.tlb_index), 64'd7);
                check("inv_wdata", 64'(bus.tlb_wdata), 64'd0);
            end
        end
        check("inv_strobe_cycles", 64'(nstrobe), 64'd1);
        @(negedge clk);

        // FIFO full during a flush, then the queue drains one write per 2 cycles.
        send(2'd3, 2'b01, 32'h0, 32'h0, 4, ok);
        check("flush_accept", 64'(ok), 64'd1);
        repeat (4) @(negedge clk);
        nacc = 0;
        for (int unsigned k = 0; k < 4; k++) begin
            send(2'd1, 2'($urandom_range(1, 3)), ($urandom & 32'hFFC0_0000) | ((k + 3) << 12),
                 $urandom, 1, ok);
            nacc += ok;
        end
        check("full_accepts", 64'(nacc), 64'd4);
        send(2'd1, 2'b11, 32'h0055_5000, 32'h0, 1, ok);
        check("full_reject", 64'(ok), 64'd0);
        seen_done = 1'b0;
        nfound = 0;
        cyc = 0;
        for (int unsigned i = 0; i < 1200 && nfound < 4; i++) begin
            @(posedge clk); #1;
            cyc++;
            if (bus.flush_done) seen_done = 1'b1;
            if (seen_done && (bus.itlb_we || bus.dtlb_we)) begin
                t[nfound] = cyc;
                nfound++;
            end
        end
        check("full_drained", 64'(nfound), 64'd4);
        for (int unsigned k = 1; k < 4; k++) check("drain_spacing", 64'(t[k] - t[k-1]), 64'd2);
        @(negedge clk);
        wait_idle("full_idle", 20);

        // NOP and target 00 are consumed without writes.
        send(2'd0, 2'b11, 32'h0000_9000, 32'h0, 4, ok);
        send(2'd1, 2'b00, 32'h0000_A000, 32'h1000, 4, ok);
        check("nop_busy", 64'(bus.busy), 64'd1);
        @(posedge clk); #1;
        check("nop_busy_drop", 64'(bus.busy), 64'd0);
        @(negedge clk);
        wait_idle("nop_idle", 10);

        // Reset in the middle of a flush discards queued commands.
        send(2'd3, 2'b11, 32'h0, 32'h0, 4, ok);
        send(2'd1, 2'b01, 32'h0001_1000, 32'h2000, 4, ok);
        send(2'd2, 2'b10, 32'h0002_2000, 32'h0, 4, ok);
        ok = 1'b0;
        for (int unsigned i = 0; i < 1200 && !ok; i++) begin
            @(posedge clk); #1;
            if (bus.stall_request && bus.tlb_index == IW'(500)) ok = 1'b1;
        end
        check("midflush_reached_500", 64'(ok), 64'd1);
        do_reset(1);

        // Randomized command stream.
        flushes = 0;
        for (int unsigned n = 0; n < 60; n++) begin
            if ($urandom_range(0, 99) < 4 && flushes < 2) begin
                op = 2'd3;
                flushes++;
            end else begin
                op = 2'($urandom_range(0, 2));
            end
            tgt = 2'($urandom_range(0, 3));
            send(op, tgt, $urandom, $urandom, 2000, ok);
            check("rand_accept", 64'(ok), 64'd1);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_idle("rand_idle", 3000);

        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
